// File: rtl/cache_ctrl.sv
// cache_ctrl -- two-way set-associative cache controller.
//
// Owns the tag/valid/dirty arrays and per-set LRU bit, sequences lookups,
// victim write-back and line refill, and drives the strobes of an external
// data array. The data path (core din, mem_dout) lives outside this block.
//
// Optional build macro: CACHE_CTRL_STATS_EN adds 32-bit hit_cnt/miss_cnt
// outputs counting LOOKUP hits and misses.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   ren, wen   core read / write request (wen wins if both are set)
//   addr       core address (tag | index | offset)
//   cache_rdy  idle and accepting requests
//   hit        one-cycle pulse on a lookup hit
//   arr_we     data-array write strobe
//   arr_way    data-array way select
//   arr_idx    data-array set index
//   arr_src    data-array write source: 0 = core din, 1 = mem_dout
//   mem_ren    memory line read request, held until mem_rdy
//   mem_wen    memory line write request, held until mem_rdy
//   mem_addr   memory line address, offset bits zero
//   mem_rdy    memory completes the current request this cycle
//   hit_cnt    (stats build only) lookup hit count
//   miss_cnt   (stats build only) lookup miss count
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | cache_rdy high, waits for ren/wen, latches request
// LOOKUP    | compares tags, completes hits, picks a victim on a miss
// WRITEBACK | dirty victim line written to memory
// REFILL    | requested line read from memory into the victim way
// UPDATE    | LRU update and, for writes, core data merged into the line
module cache_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int N_WAYS      = 2,
  parameter int NUM_SETS    = 32,
  parameter int OFFSET_BITS = 7,
  parameter int INDEX_BITS  = 5,
  parameter int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  cache_rdy,
  output logic                  hit,
  output logic                  arr_we,
  output logic                  arr_way,
  output logic [INDEX_BITS-1:0] arr_idx,
  output logic                  arr_src,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rdy
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    UPDATE    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic                  unused_offset;

  assign addr_tag      = addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign addr_idx      = addr[OFFSET_BITS +: INDEX_BITS];
  assign unused_offset = ^addr[OFFSET_BITS-1:0];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  req_wr;
  logic                  victim_q, victim_d;

  logic [N_WAYS-1:0][NUM_SETS-1:0] valid_q;
  logic [N_WAYS-1:0][NUM_SETS-1:0] dirty_q;
  logic [NUM_SETS-1:0]             lru_q;
  logic [TAG_BITS-1:0]             tag_q [N_WAYS][NUM_SETS];

  logic way0_hit, way1_hit, any_hit, hit_way, miss_victim;
  logic accept, lru_we, lru_val, meta_we, meta_way, meta_dirty, tag_we;

  assign way0_hit = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign way1_hit = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign any_hit  = way0_hit || way1_hit;
  assign hit_way  = way0_hit ? 1'b0 : 1'b1;

  // Invalid ways are filled before anything is evicted, way0 first.
  assign miss_victim = !valid_q[0][req_idx] ? 1'b0 :
                       !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  // While reset is asserted the index is forced to zero even though IDLE
  // would otherwise pass the live address index through.
  assign arr_idx = !rst ? '0 : ((state_q == IDLE) ? addr_idx : req_idx);

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    cache_rdy  = 1'b0;
    hit        = 1'b0;
    arr_we     = 1'b0;
    arr_way    = 1'b0;
    arr_src    = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    accept     = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    meta_we    = 1'b0;
    meta_way   = 1'b0;
    meta_dirty = 1'b0;
    tag_we     = 1'b0;

    case (state_q)
      IDLE: begin
        cache_rdy = 1'b1;
        if (ren || wen) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (any_hit) begin
          hit     = 1'b1;
          arr_way = hit_way;
          lru_we  = 1'b1;
          lru_val = ~hit_way;
          if (req_wr) begin
            arr_we     = 1'b1;
            meta_we    = 1'b1;
            meta_way   = hit_way;
            meta_dirty = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = miss_victim;
          if (valid_q[miss_victim][req_idx] && dirty_q[miss_victim][req_idx])
            state_d = WRITEBACK;
          else
            state_d = REFILL;
        end
      end

      WRITEBACK: begin
        mem_wen  = 1'b1;
        mem_addr = {tag_q[victim_q][req_idx], req_idx, {OFFSET_BITS{1'b0}}};
        arr_way  = victim_q;
        if (mem_rdy) state_d = REFILL;
      end

      REFILL: begin
        mem_ren  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
        arr_way  = victim_q;
        if (mem_rdy) begin
          arr_we     = 1'b1;
          arr_src    = 1'b1;
          tag_we     = 1'b1;
          meta_we    = 1'b1;
          meta_way   = victim_q;
          meta_dirty = 1'b0;
          state_d    = UPDATE;
        end
      end

      UPDATE: begin
        arr_way = victim_q;
        lru_we  = 1'b1;
        lru_val = ~victim_q;
        if (req_wr) begin
          arr_we     = 1'b1;
          meta_we    = 1'b1;
          meta_way   = victim_q;
          meta_dirty = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      req_tag  <= '0;
      req_idx  <= '0;
      req_wr   <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (accept) begin
        req_tag <= addr_tag;
        req_idx <= addr_idx;
        req_wr  <= wen;
      end
      if (lru_we) lru_q[req_idx] <= lru_val;
      // Any metadata write leaves the line valid; only dirty differs.
      if (meta_we) begin
        valid_q[meta_way][req_idx] <= 1'b1;
        dirty_q[meta_way][req_idx] <= meta_dirty;
      end
    end
  end

  // Tags are qualified by valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[victim_q][req_idx] <= req_tag;
  end

`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (any_hit) hit_cnt  <= hit_cnt + 32'd1;
      else         miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        cache_rdy, hit, arr_we, arr_way, arr_src, mem_ren, mem_wen;
  logic [4:0]  arr_idx;
  logic [31:0] mem_addr;

  int checks = 0;
  int errors = 0;

  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ren       (ren),
    .wen       (wen),
    .addr      (addr),
    .cache_rdy (cache_rdy),
    .hit       (hit),
    .arr_we    (arr_we),
    .arr_way   (arr_way),
    .arr_idx   (arr_idx),
    .arr_src   (arr_src),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_rdy   (mem_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge in LOOKUP.
  task automatic issue(input logic r, input logic w, input logic [31:0] a);
    ren  = r;
    wen  = w;
    addr = a;
    @(negedge clk);
    ren  = 1'b0;
    wen  = 1'b0;
    addr = $urandom;
  endtask

  // Completes the outstanding memory request; returns at the next negedge.
  task automatic mem_done(input string tag, input logic exp_we, input logic exp_src);
    mem_rdy = 1'b1;
    #1;
    chk({tag, "_we"}, arr_we, exp_we);
    chk({tag, "_src"}, arr_src, exp_src);
    @(negedge clk);
    mem_rdy = 1'b0;
  endtask

  initial begin
    addr = 32'h0000_1080;
    #12;
    chk("rst_rdy", cache_rdy, 1);
    chk("rst_hit", hit, 0);
    chk("rst_we", arr_we, 0);
    chk("rst_mren", mem_ren, 0);
    chk("rst_mwen", mem_wen, 0);
    chk("rst_idx", arr_idx, 0);
    chk("rst_maddr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold read miss, refill, then hit with 2-cycle latency
    ren = 1'b1; addr = 32'h0000_1080;
    #1;
    chk("idle_idx", arr_idx, 1);
    chk("idle_rdy", cache_rdy, 1);
    @(negedge clk);
    ren = 1'b0; addr = $urandom;
    chk("lk1_rdy", cache_rdy, 0);
    chk("lk1_hit", hit, 0);
    chk("lk1_idx", arr_idx, 1);
    @(negedge clk);
    chk("rf1_ren", mem_ren, 1);
    chk("rf1_wen", mem_wen, 0);
    chk("rf1_addr", mem_addr, 32'h0000_1080);
    chk("rf1_way", arr_way, 0);
    chk("rf1_idx", arr_idx, 1);
    mem_done("rf1", 1, 1);
    chk("up1_we", arr_we, 0);
    chk("up1_rdy", cache_rdy, 0);
    @(negedge clk);
    chk("id1_rdy", cache_rdy, 1);
    issue(1, 0, 32'h0000_1080);
    chk("hit1", hit, 1);
    chk("hit1_way", arr_way, 0);
    chk("hit1_we", arr_we, 0);
    @(negedge clk);
    chk("hit1_rdy", cache_rdy, 1);
    chk("hit1_pulse", hit, 0);

    // Fresh start: two writes fill ways 0 and 1 of set 1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(0, 1, 32'h0000_2080);
    chk("w1_hit", hit, 0);
    @(negedge clk);
    chk("w1_ren", mem_ren, 1);
    chk("w1_wen", mem_wen, 0);
    chk("w1_addr", mem_addr, 32'h0000_2080);
    chk("w1_way", arr_way, 0);
    mem_done("w1_rf", 1, 1);
    chk("w1_up_we", arr_we, 1);
    chk("w1_up_src", arr_src, 0);
    chk("w1_up_way", arr_way, 0);
    @(negedge clk);
    issue(0, 1, 32'h0000_3080);
    chk("w2_hit", hit, 0);
    @(negedge clk);
    chk("w2_ren", mem_ren, 1);
    chk("w2_wen", mem_wen, 0);
    chk("w2_addr", mem_addr, 32'h0000_3080);
    chk("w2_way", arr_way, 1);
    mem_done("w2_rf", 1, 1);
    chk("w2_up_we", arr_we, 1);
    chk("w2_up_src", arr_src, 0);
    chk("w2_up_way", arr_way, 1);
    @(negedge clk);

    // Read miss evicts LRU way0 (dirty, tag 0x00002)
    issue(1, 0, 32'h0000_4080);
    @(negedge clk);
    chk("wb1_wen", mem_wen, 1);
    chk("wb1_ren", mem_ren, 0);
    chk("wb1_addr", mem_addr, 32'h0000_2080);
    chk("wb1_way", arr_way, 0);
    mem_done("wb1", 0, 0);
    chk("rf3_ren", mem_ren, 1);
    chk("rf3_wen", mem_wen, 0);
    chk("rf3_addr", mem_addr, 32'h0000_4080);
    mem_done("rf3", 1, 1);
    chk("up3_we", arr_we, 0);
    @(negedge clk);

    // ren=wen=1 acts as write; victim way1 (dirty tag 3); slow memory
    issue(1, 1, 32'h0000_5080);
    @(negedge clk);
    chk("wb2_wen", mem_wen, 1);
    chk("wb2_addr", mem_addr, 32'h0000_3080);
    chk("wb2_way", arr_way, 1);
    mem_done("wb2", 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_ren", mem_ren, 1);
      chk("hold_wen", mem_wen, 0);
      chk("hold_addr", mem_addr, 32'h0000_5080);
      @(negedge clk);
    end
    mem_done("rf4", 1, 1);
    chk("both_we", arr_we, 1);
    chk("both_src", arr_src, 0);
    chk("both_way", arr_way, 1);
    @(negedge clk);

    // Clean way0 evicted without write-back, then dirty way1 written back
    issue(1, 0, 32'h0000_6080);
    @(negedge clk);
    chk("ev_ren", mem_ren, 1);
    chk("ev_wen", mem_wen, 0);
    chk("ev_addr", mem_addr, 32'h0000_6080);
    chk("ev_way", arr_way, 0);
    mem_done("ev", 1, 1);
    @(negedge clk);
    issue(1, 0, 32'h0000_7080);
    @(negedge clk);
    chk("dwb_wen", mem_wen, 1);
    chk("dwb_addr", mem_addr, 32'h0000_5080);
    chk("dwb_way", arr_way, 1);
    mem_done("dwb", 0, 0);
    chk("dwb_rf_addr", mem_addr, 32'h0000_7080);
    mem_done("dwb_rf", 1, 1);
    @(negedge clk);

    // Reset in the middle of a refill
    issue(1, 0, 32'h0000_6080);
    chk("pre_hit", hit, 1);
    @(negedge clk);
    issue(1, 0, 32'h0000_1080);
    @(negedge clk);
    chk("mid_ren", mem_ren, 1);
    chk("mid_addr", mem_addr, 32'h0000_1080);
    chk("mid_way", arr_way, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ren", mem_ren, 0);
    chk("mid_rst_rdy", cache_rdy, 1);
    chk("mid_rst_maddr", mem_addr, 0);
    chk("mid_rst_idx", arr_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1, 0, 32'h0000_6080);
    chk("post_hit", hit, 0);
    @(negedge clk);
    chk("post_ren", mem_ren, 1);
    chk("post_wen", mem_wen, 0);
    chk("post_addr", mem_addr, 32'h0000_6080);
    chk("post_way", arr_way, 0);
    mem_done("post", 1, 1);
    @(negedge clk);
    chk("post_rdy", cache_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH=32 (address width); N_WAYS=2 (associativity, only 2 supported); NUM_SETS=32 (sets); OFFSET_BITS=7 (line offset); INDEX_BITS=5 (set index); TAG_BITS=20 (tag, =ADDR_WIDTH-INDEX_BITS-OFFSET_BITS).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ren / wen  in  1 each  core read / write request.
REQ-005 addr  in  ADDR_WIDTH  core address; tag=addr[31:12], index=addr[11:7].
REQ-006 cache_rdy  out  1  controller idle and accepting requests.
REQ-007 hit  out  1  one-cycle pulse when a lookup hits.
REQ-008 arr_we  out  1  data-array write strobe.
REQ-009 arr_way  out  1  data-array way select (reads and writes).
REQ-010 arr_idx  out  INDEX_BITS  data-array set index.
REQ-011 arr_src  out  1  write data source: 0=core din, 1=mem_dout.
REQ-012 mem_ren / mem_wen  out  1 each  memory read / write request, level, held until mem_rdy.
REQ-013 mem_addr  out  ADDR_WIDTH  memory line address, offset bits zero.
REQ-014 mem_rdy  in  1  memory completes the current request this cycle.

Function
REQ-015 SHALL own per-set, per-way tag, valid and dirty arrays plus one LRU bit per set (LRU=way not most recently used).
REQ-016 States: IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE; cache_rdy=1 only in IDLE.
REQ-017 IDLE: on ren|wen latch addr and op (wen takes priority if both set), go to LOOKUP next cycle.
REQ-018 LOOKUP hit (valid & tag match on a way): hit=1, arr_way=hit way, LRU=other way; on write arr_we=1, arr_src=0, dirty=1; go to IDLE (2-cycle hit latency, request edge to cache_rdy).
REQ-019 LOOKUP miss: victim=first invalid way (way0 before way1), else the LRU way; dirty valid victim -> WRITEBACK, otherwise -> REFILL.
REQ-020 WRITEBACK: mem_wen=1, mem_addr={victim tag, index, 0}, arr_way=victim; on mem_rdy -> REFILL.
REQ-021 REFILL: mem_ren=1, mem_addr={req tag, index, 0}; on mem_rdy: arr_we=1, arr_src=1, tag written, valid=1, dirty=0 -> UPDATE.
REQ-022 UPDATE: arr_way=victim, LRU=other way; on write arr_we=1, arr_src=0, dirty=1; -> IDLE.
REQ-023 mem_ren and mem_wen SHALL never both be 1; memory strobes SHALL not deassert before mem_rdy.
REQ-024 ren/wen SHALL be ignored outside IDLE; addr changes after acceptance SHALL not affect the transaction.
REQ-025 arr_idx SHALL equal the latched index in all non-IDLE states, and addr index in IDLE.

Reset
REQ-026 rst low SHALL immediately force IDLE, all valid/dirty/LRU bits 0, cache_rdy=1, hit/arr_we/arr_way/arr_src/mem_ren/mem_wen=0, arr_idx/mem_addr=0, including mid WRITEBACK/REFILL.
REQ-027 Tag contents SHALL not require reset.

Configuration
REQ-028 With CACHE_CTRL_STATS_EN defined: outputs hit_cnt and miss_cnt (32 bits each) count LOOKUP hits and misses, wrap at 2^32, reset to 0; without it these ports and counters SHALL not exist, behaviour otherwise identical.

Verification
REQ-029 After reset, read 0x0000_1080 -> miss, REFILL mem_addr=0x0000_1080, no WRITEBACK, then repeat read -> hit=1, cache_rdy 2 cycles after request.
REQ-030 Write 0x0000_2080 then 0x0000_3080 (same set 1) -> both fill invalid ways 0 then 1, both dirty, no memory writes.
REQ-031 Then read 0x0000_4080 -> LRU victim way0 (tag 0x00002) written back at mem_addr=0x0000_2080, then REFILL 0x0000_4080.
REQ-032 ren=wen=1 in IDLE -> treated as write, dirty set; mem_rdy held low 10 cycles -> mem_ren held steady 10 cycles.
REQ-033 rst low during REFILL -> mem_ren=0 same cycle, cache_rdy=1, subsequent read of prior hit address misses.
